// File: rtl/sync_data_memory_pkg.sv
// Shared types and elaboration helpers for the synchronous data memory.
package sync_data_memory_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } mem_state_e;

   // A one- or two-word memory still needs a one-bit address.
   function automatic int addr_w_f(input int depth);
      if (depth <= 2) return 1;
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_data_memory_if.sv
// Request/response bus between the load/store unit and the data memory.
interface sync_data_memory_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              init_done;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
   );
endinterface

// File: rtl/sync_data_memory_core.sv
// DEPTH x DATA_W storage array: one write port, one registered read port.
module sync_data_memory_core #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Callers only enable the ports with in-range addresses.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_data_memory.sv
// Synchronous data memory: post-reset clear sequence, valid/ready request port,
// single-entry registered load response with backpressure.
module sync_data_memory
   import sync_data_memory_pkg::*;
#(
   parameter int              DATA_W   = 8,
   parameter int              DEPTH    = 32,
   parameter int              ADDR_W   = addr_w_f(DEPTH),
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   sync_data_memory_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;

   logic              req_ready;
   logic              accept;
   logic              in_range;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;

   assign in_range = ({1'b0, bus.req_addr} < DEPTH_EXT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      req_ready   = 1'b0;
      accept      = 1'b0;
      ram_we      = 1'b0;
      ram_waddr   = bus.req_addr;
      ram_wdata   = bus.req_wdata;
      ram_re      = 1'b0;

      case (state_q)
         CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = INIT_VAL;
            // Terminal compare: the counter never runs past the last word.
            if (clr_cnt_q == LAST_ADDR) state_d = RUN;
            else                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         end
         RUN: begin
            req_ready = !rsp_valid_q || bus.rsp_ready;
            accept    = bus.req_valid && req_ready;
            if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
            if (accept) begin
               if (bus.req_write) begin
                  ram_we = in_range;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = !in_range;
                  ram_re      = in_range;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   sync_data_memory_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (bus.req_addr),
      .rdata_o (ram_rdata)
   );

   // The read register only updates on in-range loads, so errors mask it to zero.
   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_err_q ? '0 : ram_rdata;
   assign bus.init_done = (state_q == RUN);

endmodule
